// File: rtl/cordic_post_stage_pkg.sv
// cordic_post_stage_pkg: sector, angle and mode constants shared by the CORDIC post stage
package cordic_post_stage_pkg;
  localparam logic [1:0] SECTOR_Q0 = 2'd0;
  localparam logic [1:0] SECTOR_Q1 = 2'd1;
  localparam logic [1:0] SECTOR_Q2 = 2'd2;
  localparam logic [1:0] SECTOR_Q3 = 2'd3;
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;
  function automatic int angle_90(input int frac_width);
    return 90 << frac_width;
  endfunction
endpackage

// File: rtl/cordic_post_stage_sync_fifo.sv
// sync_fifo: show-ahead FIFO with occupancy output; data reads as 0 while empty
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= din;
  assign level = wr - rd;
  assign valid = level != '0;
  assign dout = valid ? mem[rd[AW-1:0]] : '0;
endmodule

// File: rtl/cordic_post_stage.sv
// cordic_post_stage: tags real pipeline samples, reconstructs the quadrant and buffers
// results behind valid/ready, with credit-based issue flow control
module cordic_post_stage
  import cordic_post_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int SECTOR_FLAG_WIDTH = 2,
  parameter int PIPE_LATENCY = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int OW = DATA_WIDTH + 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [DATA_WIDTH-1:0]        degree_in,
  input  logic [DATA_WIDTH-1:0]        x_in,
  input  logic [DATA_WIDTH-1:0]        y_in,
  input  logic [SECTOR_FLAG_WIDTH-1:0] sector_in,
  input  logic                         arctan_en_in,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [OW-1:0]                m_x_o,
  output logic [OW-1:0]                m_y_o,
  output logic [OW-1:0]                m_degree_o,
  output logic                         m_mode_o,
  output logic [LW-1:0]                level_o,
  output logic                         overflow_o
);
  localparam logic [OW-1:0] A90 = OW'(angle_90(FRAC_WIDTH));
  logic [LW-1:0] reserved;
  logic [PIPE_LATENCY-1:0] tags;
  logic accept, pop, push;
  logic [OW-1:0] xe, ye, cx, cy, cdeg;
  assign issue_ready_o = reserved < LW'(FIFO_DEPTH);
  assign accept = issue_valid_i & issue_ready_o;
  assign pop = m_valid_o & m_ready_i;
  assign push = tags[PIPE_LATENCY-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reserved <= '0;
      tags <= '0;
      overflow_o <= 1'b0;
    end else begin
      reserved <= reserved + LW'(accept) - LW'(pop);
      tags <= (tags << 1) | PIPE_LATENCY'(accept);
      if (issue_valid_i && !issue_ready_o) overflow_o <= 1'b1;
    end
  // The pipeline only solves the first quadrant; rotate back by the sector flag
  assign xe = {1'b0, x_in};
  assign ye = {1'b0, y_in};
  always_comb begin
    cx = sector_in == SECTOR_FLAG_WIDTH'(SECTOR_Q0) ? xe :
         sector_in == SECTOR_FLAG_WIDTH'(SECTOR_Q1) ? -ye :
         sector_in == SECTOR_FLAG_WIDTH'(SECTOR_Q2) ? -xe : ye;
    cy = sector_in == SECTOR_FLAG_WIDTH'(SECTOR_Q0) ? ye :
         sector_in == SECTOR_FLAG_WIDTH'(SECTOR_Q1) ? xe :
         sector_in == SECTOR_FLAG_WIDTH'(SECTOR_Q2) ? -ye : -xe;
    cdeg = {1'b0, degree_in} + OW'(sector_in) * A90;
  end
  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3 * OW + 1)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({arctan_en_in, cdeg, cy, cx}),
    .pop(pop),
    .dout({m_mode_o, m_degree_o, m_y_o, m_x_o}),
    .valid(m_valid_o),
    .level(level_o)
  );
endmodule

// File: tb/tb_cordic_post_stage.sv
// tb_cordic_post_stage: directed tests checked against a queue-based behavioural model
module tb_cordic_post_stage;
  localparam int L = 8;
  localparam int DEPTH = 16;
  typedef struct {logic [16:0] x, y, d; logic m;} ent_t;
  logic clk = 0, reset = 0, issue_valid_i = 0, issue_ready_o, arctan_en_in = 0;
  logic [15:0] degree_in = 0, x_in = 0, y_in = 0;
  logic [1:0] sector_in = 0;
  logic m_valid_o, m_ready_i = 0, m_mode_o, overflow_o;
  logic [16:0] m_x_o, m_y_o, m_degree_o;
  logic [4:0] level_o;
  int total = 0, bad = 0, cyc = 0, acc, npop;
  int inflight[$];
  ent_t fq[$];
  bit ovf = 0;

  cordic_post_stage dut (
    .clk(clk), .reset(reset), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .degree_in(degree_in), .x_in(x_in), .y_in(y_in), .sector_in(sector_in),
    .arctan_en_in(arctan_en_in), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_x_o(m_x_o), .m_y_o(m_y_o), .m_degree_o(m_degree_o), .m_mode_o(m_mode_o),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", n, $time, a, e);
    end
  endtask

  function automatic ent_t correct(input int x, input int y, input int d, input int s, input logic m);
    ent_t e;
    int nx, ny;
    case (s)
      0: begin nx = x; ny = y; end
      1: begin nx = -y; ny = x; end
      2: begin nx = -x; ny = -y; end
      default: begin nx = y; ny = -x; end
    endcase
    e.x = 17'(nx);
    e.y = 17'(ny);
    e.d = 17'(d + s * 90 * 256);
    e.m = m;
    return e;
  endfunction

  // Model: credits = in-flight + buffered; results land L edges after their issue edge
  always @(negedge clk) begin
    bit exp_ready, p;
    if (!reset) begin
      inflight.delete();
      fq.delete();
      ovf = 0;
    end
    exp_ready = (inflight.size() + fq.size()) < DEPTH;
    chk("ready", issue_ready_o, exp_ready);
    chk("valid", m_valid_o, fq.size() > 0);
    chk("level", level_o, fq.size());
    chk("overflow", overflow_o, ovf);
    chk("x", m_x_o, fq.size() ? fq[0].x : 0);
    chk("y", m_y_o, fq.size() ? fq[0].y : 0);
    chk("deg", m_degree_o, fq.size() ? fq[0].d : 0);
    chk("mode", m_mode_o, fq.size() ? fq[0].m : 0);
    if (reset) begin
      p = fq.size() > 0 && m_ready_i;
      if (issue_valid_i && !exp_ready) ovf = 1;
      if (p) void'(fq.pop_front());
      if (inflight.size() && inflight[0] == cyc) begin
        void'(inflight.pop_front());
        fq.push_back(correct(x_in, y_in, degree_in, sector_in, arctan_en_in));
      end
      if (issue_valid_i && exp_ready) inflight.push_back(cyc + L);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    x_in = 16'($urandom);
    y_in = 16'($urandom);
    degree_in = 16'($urandom_range(0, 16'h59FF));
    sector_in = 2'($urandom);
    arctan_en_in = 1'($urandom);
  endtask

  task automatic drain();
    m_ready_i = 1;
    repeat (20) step();
    m_ready_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [16:0] ex [4], ey [4], ed [4];
    ex = '{17'h100, 17'h0, 17'h1FF00, 17'h0};
    ey = '{17'h0, 17'h100, 17'h0, 17'h1FF00};
    ed = '{17'h0, 17'h5A00, 17'hB400, 17'h10E00};
    #1;
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_valid", m_valid_o, 0);
    repeat (2) step();
    reset = 1;
    step();

    // sector 1 correction with latency check
    issue_valid_i = 1;
    step();
    issue_valid_i = 0;
    repeat (L - 1) step();
    x_in = 16'h0100; y_in = 16'h01BB; degree_in = 16'h1E00; sector_in = 2'd1; arctan_en_in = 0;
    chk("s1_not_yet", m_valid_o, 0);
    step();
    chk("s1_valid", m_valid_o, 1);
    chk("s1_x", m_x_o, 17'h1FE45);
    chk("s1_y", m_y_o, 17'h00100);
    chk("s1_deg", m_degree_o, 17'h07800);
    drain();

    // all four sectors
    issue_valid_i = 1;
    repeat (4) step();
    issue_valid_i = 0;
    repeat (L - 4) step();
    for (int s = 0; s < 4; s++) begin
      x_in = 16'h0100; y_in = 0; degree_in = 0; sector_in = 2'(s); arctan_en_in = 0;
      step();
    end
    for (int s = 0; s < 4; s++) begin
      chk("q_x", m_x_o, ex[s]);
      chk("q_y", m_y_o, ey[s]);
      chk("q_deg", m_degree_o, ed[s]);
      m_ready_i = 1;
      step();
      m_ready_i = 0;
    end
    chk("q_empty", m_valid_o, 0);

    // credit exhaustion
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      issue_valid_i = issue_ready_o;
      if (issue_ready_o) acc++;
      step();
    end
    issue_valid_i = 0;
    chk("cr_accepts", acc, 16);
    repeat (L + 2) step();
    chk("cr_level", level_o, 16);
    chk("cr_ready", issue_ready_o, 0);
    chk("cr_ovf", overflow_o, 0);

    // issue without credit
    issue_valid_i = 1;
    step();
    issue_valid_i = 0;
    repeat (L + 2) step();
    chk("nc_ovf", overflow_o, 1);
    chk("nc_level", level_o, 16);
    drain();
    chk("nc_ovf_held", overflow_o, 1);

    // sparse tags, outputs changing every cycle
    npop = 0;
    m_ready_i = 1;
    for (int i = 0; i < 4 + L + 6; i++) begin
      issue_valid_i = (i == 0 || i == 2 || i == 3);
      if (m_valid_o) npop++;
      step();
    end
    issue_valid_i = 0;
    m_ready_i = 0;
    chk("sp_count", npop, 3);

    // reset with 5 in flight and 3 buffered
    issue_valid_i = 1;
    repeat (8) step();
    issue_valid_i = 0;
    repeat (3) step();
    chk("rm_level_before", level_o, 3);
    reset = 0;
    #1;
    chk("rm_valid", m_valid_o, 0);
    chk("rm_level", level_o, 0);
    chk("rm_ready", issue_ready_o, 1);
    chk("rm_ovf", overflow_o, 0);
    repeat (2) step();
    reset = 1;
    repeat (15) step();
    chk("rm_after", level_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
